// File: rtl/firebird7_in_gate1_tessent_tdr_w19_override.sv
// IJTAG override/observe test data register: a WIDTH+1 bit scan chain (select bit plus data)
// with a shadow update register that drives a data mux, and a sticky mis-length shift flag.
module firebird7_in_gate1_tessent_tdr_w19_override #(
    parameter int WIDTH = 19
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    input  logic [WIDTH-1:0] observe_data,
    output logic             ijtag_so,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             ijtag_select,
    output logic             length_error
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH:0]  sr_q, sr_d;
    logic [WIDTH:0]  ur_q, ur_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            len_err_q, len_err_d;

    logic            capture_en;
    logic            shift_en;
    logic            update_en;

    assign capture_en = ijtag_sel & ijtag_ce;
    assign shift_en   = ijtag_sel & ijtag_se & ~ijtag_ce;
    assign update_en  = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;

    always_comb begin
        sr_d      = sr_q;
        ur_d      = ur_q;
        cnt_d     = cnt_q;
        len_err_d = len_err_q;

        if (capture_en) begin
            // Capture readback includes the currently applied select so a rewrite preserves it.
            sr_d  = {observe_data, ur_q[0]};
            cnt_d = '0;
        end else if (shift_en) begin
            sr_d  = {ijtag_si, sr_q[WIDTH:1]};
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
        end else if (update_en) begin
            // Only a whole multiple of the chain length may reach the update register.
            if (cnt_q == '0) begin
                ur_d = sr_q;
            end else begin
                len_err_d = 1'b1;
                cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            sr_q      <= '0;
            ur_q      <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            ur_q      <= ur_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign ijtag_so       = sr_q[0];
    assign ijtag_select   = ur_q[0];
    assign ijtag_data_out = ur_q[WIDTH:1];
    assign length_error   = len_err_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_override.sv
// Scoreboard bench for the override TDR: expected scan-out bits and output words are queued
// as stimulus is issued and compared when the DUT presents them.
module tb_firebird7_in_gate1_tessent_tdr_w19_override;

    localparam int WIDTH = 19;

    logic             ijtag_tck = 1'b0;
    logic             ijtag_reset = 1'b1;
    logic             ijtag_sel = 1'b0;
    logic             ijtag_ce = 1'b0;
    logic             ijtag_se = 1'b0;
    logic             ijtag_ue = 1'b0;
    logic             ijtag_si = 1'b0;
    logic [WIDTH-1:0] observe_data = '0;
    logic             ijtag_so;
    logic [WIDTH-1:0] ijtag_data_out;
    logic             ijtag_select;
    logic             length_error;

    firebird7_in_gate1_tessent_tdr_w19_override #(.WIDTH(WIDTH)) dut (
        .ijtag_tck      (ijtag_tck),
        .ijtag_reset    (ijtag_reset),
        .ijtag_sel      (ijtag_sel),
        .ijtag_ce       (ijtag_ce),
        .ijtag_se       (ijtag_se),
        .ijtag_ue       (ijtag_ue),
        .ijtag_si       (ijtag_si),
        .observe_data   (observe_data),
        .ijtag_so       (ijtag_so),
        .ijtag_data_out (ijtag_data_out),
        .ijtag_select   (ijtag_select),
        .length_error   (length_error)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    // Advance to just after the next rising edge so outputs are settled.
    task automatic tick();
        @(posedge ijtag_tck);
        #1;
    endtask

    // Expected scan-out stream: the low n bits of a chain word, LSB first.
    task automatic push_so(input string tag, input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) sb_push($sformatf("%s_so%0d", tag, i), {31'd0, w[i % 32]});
    endtask

    task automatic push_out(input string tag, input logic sel_v, input logic [WIDTH-1:0] d_v,
                            input logic le_v);
        sb_push({tag, "_select"}, {31'd0, sel_v});
        sb_push({tag, "_data"}, {13'd0, d_v});
        sb_push({tag, "_lerr"}, {31'd0, le_v});
    endtask

    task automatic pop_out();
        sb_pop_check({31'd0, ijtag_select});
        sb_pop_check({13'd0, ijtag_data_out});
        sb_pop_check({31'd0, length_error});
    endtask

    task automatic do_capture();
        ijtag_ce = 1'b1;
        tick();
        ijtag_ce = 1'b0;
    endtask

    // Shift n bits of w LSB first; scan-out is compared before each shifting edge.
    task automatic do_shift(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ijtag_si = w[i % 32];
            ijtag_se = 1'b1;
            sb_pop_check({31'd0, ijtag_so});
            tick();
        end
        ijtag_se = 1'b0;
        ijtag_si = 1'b0;
    endtask

    task automatic do_update();
        ijtag_ue = 1'b1;
        tick();
        ijtag_ue = 1'b0;
        pop_out();
    endtask

    logic [31:0] pat_p, pat_q, pat_r, pat_s, pat_x, cap_w;

    initial begin
        pat_p = {12'd0, 19'h5A5A5, 1'b1};
        pat_q = {12'd0, 19'h0F0F0, 1'b0};
        pat_r = {12'd0, 19'h3C3C3, 1'b1};
        pat_s = {12'd0, 19'h1E2D4, 1'b1};
        pat_x = 32'h000ABCDE;

        // Reset state
        #12;
        push_out("rst", 1'b0, '0, 1'b0);
        sb_push("rst_so", 32'd0);
        pop_out();
        sb_pop_check({31'd0, ijtag_so});
        #1 ijtag_reset = 1'b0;
        tick();
        ijtag_sel = 1'b1;

        // Full-length load
        do_capture();
        push_so("load", 32'd0, 20);
        do_shift(pat_p, 20);
        push_out("load", 1'b1, 19'h5A5A5, 1'b0);
        do_update();

        // Readback of observe_data, with select bit first
        observe_data = 19'h12345;
        do_capture();
        cap_w = {12'd0, 19'h12345, 1'b1};
        push_so("obs", cap_w, 20);
        do_shift(pat_p, 20);
        push_out("obs", 1'b1, 19'h5A5A5, 1'b0);
        do_update();

        // Short shift is rejected and flagged
        do_capture();
        push_so("short", cap_w, 7);
        do_shift(32'hFFFFFFFF, 7);
        push_out("short", 1'b1, 19'h5A5A5, 1'b1);
        do_update();
        do_capture();
        push_so("after_short", cap_w, 20);
        do_shift(pat_q, 20);
        push_out("after_short", 1'b0, 19'h0F0F0, 1'b1);
        do_update();

        // Double-length shift wraps the counter and is accepted
        do_capture();
        cap_w = {12'd0, 19'h12345, 1'b0};
        push_so("wrap_a", cap_w, 20);
        push_so("wrap_b", pat_x, 20);
        do_shift(pat_x, 20);
        do_shift(pat_r, 20);
        push_out("wrap", 1'b1, 19'h3C3C3, 1'b1);
        do_update();

        // Simultaneous ce/se: capture only, then an immediate update rewrites
        observe_data = 19'h6B1D2;
        ijtag_ce = 1'b1;
        ijtag_se = 1'b1;
        ijtag_si = 1'b0;
        tick();
        ijtag_ce = 1'b0;
        ijtag_se = 1'b0;
        sb_push("cese_so", 32'd1);
        sb_pop_check({31'd0, ijtag_so});

        // Deselected pulses must not disturb anything
        ijtag_sel = 1'b0;
        observe_data = 19'h7FFFF;
        ijtag_ce = 1'b1; tick(); ijtag_ce = 1'b0;
        ijtag_se = 1'b1; ijtag_si = 1'b0; tick(); ijtag_se = 1'b0;
        ijtag_ue = 1'b1; tick(); ijtag_ue = 1'b0;
        sb_push("desel_so", 32'd1);
        sb_pop_check({31'd0, ijtag_so});
        push_out("desel", 1'b1, 19'h3C3C3, 1'b1);
        pop_out();
        ijtag_sel = 1'b1;
        push_out("rewrite", 1'b1, 19'h6B1D2, 1'b1);
        do_update();

        // Reset mid-shift aborts and clears everything without a clock edge
        observe_data = 19'h12345;
        do_capture();
        cap_w = {12'd0, 19'h12345, 1'b1};
        push_so("abort", cap_w, 10);
        do_shift(pat_p, 10);
        ijtag_reset = 1'b1;
        #1;
        push_out("midrst", 1'b0, '0, 1'b0);
        sb_push("midrst_so", 32'd0);
        pop_out();
        sb_pop_check({31'd0, ijtag_so});
        #1 ijtag_reset = 1'b0;
        tick();
        do_capture();
        cap_w = {12'd0, 19'h12345, 1'b0};
        push_so("postrst", cap_w, 20);
        do_shift(pat_s, 20);
        push_out("postrst", 1'b1, 19'h1E2D4, 1'b0);
        do_update();

        if (sb_q.size() != 0) check_val("sb_leftover", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end

endmodule
